// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate data cache between the CPU data port and data_memory.
// Latency: hits are zero-wait (combinational); a clean miss stalls N+3 cycles and a dirty miss 2N+5.
// Backpressure: o_busywait stalls the CPU; the i_mem_busywait handshake paces the block transfers.
module data_cache #(
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2,
  parameter int TAG_W    = 3
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_read,
  input  logic                        i_write,
  input  logic [7:0]                  i_address,
  input  logic [7:0]                  i_writedata,
  output logic [7:0]                  o_readdata,
  output logic                        o_busywait,
  output logic                        o_mem_read,
  output logic                        o_mem_write,
  output logic [TAG_W+INDEX_W-1:0]    o_mem_address,
  output logic [(8<<OFFSET_W)-1:0]    o_mem_writedata,
  input  logic [(8<<OFFSET_W)-1:0]    i_mem_readdata,
  input  logic                        i_mem_busywait
);

  localparam int NBLK  = 1 << INDEX_W;
  localparam int BLK_W = 8 << OFFSET_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WBACK  = 2'd1;
  localparam logic [1:0] S_FETCH  = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  logic [BLK_W-1:0] r_data [NBLK];
  logic [TAG_W-1:0] r_tag  [NBLK];
  logic [NBLK-1:0]  r_valid;
  logic [NBLK-1:0]  r_dirty;
  logic [1:0]       r_state;
  logic             r_mem_seen;
  logic [BLK_W-1:0] r_block;

  logic [INDEX_W-1:0]  w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [OFFSET_W+2:0] w_bsel;
  logic                w_hit;
  logic                w_req;
  logic                w_idle;
  logic                w_mem_done;

  assign w_idx      = i_address[OFFSET_W +: INDEX_W];
  assign w_tag      = i_address[OFFSET_W+INDEX_W +: TAG_W];
  assign w_bsel     = {i_address[OFFSET_W-1:0], 3'b000};
  assign w_hit      = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_req      = i_read | i_write;
  assign w_idle     = (r_state == S_IDLE);
  // A transfer is complete once memory has been seen busy and has since dropped busy.
  assign w_mem_done = r_mem_seen & ~i_mem_busywait;

  assign o_busywait = w_req & ~(w_idle & w_hit);
  assign o_readdata = (i_read & w_hit & w_idle) ? r_data[w_idx][w_bsel +: 8] : 8'h00;

  // Memory-side request signals are decoded purely from the FSM state.
  always_comb begin
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_mem_address   = '0;
    o_mem_writedata = '0;
    case (r_state)
      S_WBACK: begin
        o_mem_write     = 1'b1;
        o_mem_address   = {r_tag[w_idx], w_idx};
        o_mem_writedata = r_data[w_idx];
      end
      S_FETCH: begin
        o_mem_read    = 1'b1;
        o_mem_address = {w_tag, w_idx};
      end
      default: ;
    endcase
  end

  // Miss FSM plus valid/dirty bookkeeping; reset drops any in-flight transfer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_mem_seen <= 1'b0;
      r_valid    <= '0;
      r_dirty    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req & ~w_hit) begin
            r_state    <= (r_valid[w_idx] & r_dirty[w_idx]) ? S_WBACK : S_FETCH;
            r_mem_seen <= 1'b0;
          end else if (i_write & w_hit) begin
            r_dirty[w_idx] <= 1'b1;
          end
        end
        S_WBACK: begin
          if (w_mem_done) begin
            r_state    <= S_FETCH;
            r_mem_seen <= 1'b0;
          end else if (i_mem_busywait) begin
            r_mem_seen <= 1'b1;
          end
        end
        S_FETCH: begin
          if (w_mem_done) begin
            r_state    <= S_UPDATE;
            r_mem_seen <= 1'b0;
          end else if (i_mem_busywait) begin
            r_mem_seen <= 1'b1;
          end
        end
        S_UPDATE: begin
          r_valid[w_idx] <= 1'b1;
          r_dirty[w_idx] <= 1'b0;
          r_state        <= S_IDLE;
          r_mem_seen     <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data/tag storage: byte writes on hit, block capture on fetch, refill on update (never cleared).
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (w_idle && i_write && w_hit) begin
        r_data[w_idx][w_bsel +: 8] <= i_writedata;
      end
      if ((r_state == S_FETCH) && w_mem_done) begin
        r_block <= i_mem_readdata;
      end
      if (r_state == S_UPDATE) begin
        r_data[w_idx] <= r_block;
        r_tag[w_idx]  <= w_tag;
      end
    end
  end

endmodule
